// File: rtl/fetch_queue_if.sv
// Instruction-bus and fetch-window signals of the fetch front end.
// master: the fetch queue; slave: the bus/schedule side driving it.
interface fetch_queue_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned FETCH_LEN = 2,
    parameter int unsigned FETCH_OFF = 2
);
    logic                      imem_req;
    logic [XLEN-1:0]           imem_addr;
    logic                      imem_gnt;
    logic                      imem_ack;
    logic [FETCH_LEN*XLEN-1:0] imem_rdata;
    logic                      imem_err;
    logic [FETCH_LEN-1:0]      fetch_vld;
    logic [FETCH_LEN*XLEN-1:0] fetch_instr;
    logic [FETCH_LEN*XLEN-1:0] fetch_pc;
    logic [FETCH_LEN-1:0]      fetch_err;
    logic [FETCH_OFF-1:0]      fetch_offset;
    logic                      jump_vld;
    logic [XLEN-1:0]           jump_pc;

    modport master (
        output imem_req, imem_addr, fetch_vld, fetch_instr, fetch_pc, fetch_err,
        input  imem_gnt, imem_ack, imem_rdata, imem_err, fetch_offset, jump_vld, jump_pc
    );

    modport slave (
        input  imem_req, imem_addr, fetch_vld, fetch_instr, fetch_pc, fetch_err,
        output imem_gnt, imem_ack, imem_rdata, imem_err, fetch_offset, jump_vld, jump_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: in-order multi-word bus reads buffered in a circular
// queue, oldest FETCH_LEN entries presented as the fetch window.
module fetch_queue #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     FETCH_LEN = 2,
    parameter int unsigned     FETCH_OFF = 2,
    parameter int unsigned     QUEUE_LEN = 8,
    parameter int unsigned     MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input logic           clk,
    input logic           rst,
    fetch_queue_if.master bus
);
    localparam int unsigned     PtrW   = $clog2(QUEUE_LEN);
    localparam int unsigned     CntW   = $clog2(QUEUE_LEN + 1);
    localparam int unsigned     OutW   = $clog2(MAX_OUTST + 1);
    localparam logic [XLEN-1:0] Stride = XLEN'(4 * FETCH_LEN);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e               state_q;
    logic [PtrW-1:0]      head_q, tail_q;
    logic [CntW-1:0]      count_q, count_d;
    logic [OutW-1:0]      outst_q, outst_d, drop_q;
    logic [XLEN-1:0]      req_pc_q, resp_pc_q;
    logic [XLEN-1:0]      instr_q [QUEUE_LEN];
    logic [XLEN-1:0]      pc_q    [QUEUE_LEN];
    logic [QUEUE_LEN-1:0] err_q;

    logic [FETCH_OFF-1:0] offset;
    logic [CntW-1:0]      consume;
    logic [31:0]          credit;
    logic                 fire, discard, accept;

    // Credit counts queue slots already reserved by outstanding requests, so an
    // accepted response always has room.
    assign credit = 32'(count_q) + FETCH_LEN * (32'(outst_q) + 32'd1);

    assign bus.imem_req  = ~rst & (state_q == StRun) & ~bus.jump_vld
                         & (32'(outst_q) < MAX_OUTST) & (credit <= QUEUE_LEN);
    assign bus.imem_addr = req_pc_q;

    always_comb begin
        offset  = bus.fetch_offset;
        consume = CntW'(offset);
        fire    = bus.imem_req & bus.imem_gnt;
        discard = bus.imem_ack & (drop_q != '0);
        accept  = bus.imem_ack & ~discard & ~bus.jump_vld;
        outst_d = outst_q + OutW'(fire) - OutW'(bus.imem_ack);
        count_d = count_q - consume + (accept ? CntW'(FETCH_LEN) : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StRun;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            outst_q   <= '0;
            drop_q    <= '0;
            req_pc_q  <= RESET_PC;
            resp_pc_q <= RESET_PC;
            err_q     <= '0;
            for (int i = 0; i < QUEUE_LEN; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (bus.jump_vld) begin
            // Everything still in flight after this edge belongs to the old stream.
            head_q    <= tail_q;
            count_q   <= '0;
            outst_q   <= outst_d;
            drop_q    <= outst_d;
            req_pc_q  <= {bus.jump_pc[XLEN-1:2], 2'b00};
            resp_pc_q <= {bus.jump_pc[XLEN-1:2], 2'b00};
            state_q   <= StRun;
        end else begin
            head_q  <= head_q + PtrW'(offset);
            count_q <= count_d;
            outst_q <= outst_d;
            if (discard) begin
                drop_q <= drop_q - OutW'(1);
            end
            if (fire) begin
                req_pc_q <= req_pc_q + Stride;
            end
            if (accept) begin
                for (int k = 0; k < FETCH_LEN; k++) begin
                    instr_q[tail_q + PtrW'(k)] <= bus.imem_rdata[k*XLEN +: XLEN];
                    pc_q[tail_q + PtrW'(k)]    <= resp_pc_q + XLEN'(4 * k);
                    err_q[tail_q + PtrW'(k)]   <= bus.imem_err;
                end
                tail_q    <= tail_q + PtrW'(FETCH_LEN);
                resp_pc_q <= resp_pc_q + Stride;
                if (bus.imem_err) begin
                    state_q <= StHalt;
                end
            end
        end
    end

    always_comb begin
        bus.fetch_vld   = '0;
        bus.fetch_instr = '0;
        bus.fetch_pc    = '0;
        bus.fetch_err   = '0;
        for (int i = 0; i < FETCH_LEN; i++) begin
            if (CntW'(i) < count_q) begin
                bus.fetch_vld[i]               = 1'b1;
                bus.fetch_instr[i*XLEN +: XLEN] = instr_q[head_q + PtrW'(i)];
                bus.fetch_pc[i*XLEN +: XLEN]    = pc_q[head_q + PtrW'(i)];
                bus.fetch_err[i]               = err_q[head_q + PtrW'(i)];
            end
        end
    end

    offset_legal: assert property (@(posedge clk) disable iff (rst)
        !bus.jump_vld |-> (consume <= count_q));
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a reactive bus responder plus a scoreboard of
// expected window entries, pushed on ack and popped as the window is consumed.
module tb_fetch_queue;
    localparam int unsigned FL = 2;
    localparam int unsigned QL = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        bit          drop;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(32), .FETCH_LEN(FL), .FETCH_OFF(2)) bus ();

    fetch_queue #(
        .XLEN(32), .FETCH_LEN(FL), .FETCH_OFF(2), .QUEUE_LEN(QL), .MAX_OUTST(2),
        .RESET_PC(32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ent_t        exp_q[$];
    req_t        pend[$];
    logic [31:0] exp_req_pc;
    bit          halted;
    int          n_assert;
    int          n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5a5a_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_assert++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    task automatic check_window();
        int n;
        logic [1:0] ev;
        n  = (exp_q.size() < FL) ? exp_q.size() : FL;
        ev = '0;
        for (int i = 0; i < n; i++) ev[i] = 1'b1;
        chk("fetch_vld", 32'(bus.fetch_vld), 32'(ev));
        for (int i = 0; i < FL; i++) begin
            if (i < n) begin
                chk("fetch_pc", bus.fetch_pc[i*32 +: 32], exp_q[i].pc);
                chk("fetch_instr", bus.fetch_instr[i*32 +: 32], exp_q[i].instr);
                chk("fetch_err", 32'(bus.fetch_err[i]), 32'(exp_q[i].err));
            end else begin
                chk("fetch_pc_idle", bus.fetch_pc[i*32 +: 32], 32'h0);
                chk("fetch_instr_idle", bus.fetch_instr[i*32 +: 32], 32'h0);
                chk("fetch_err_idle", 32'(bus.fetch_err[i]), 32'h0);
            end
        end
    endtask

    // One clock: check window, consume, predict request, respond, update the model.
    task automatic step(input int want, input bit gnt_en, input bit ack_en,
                        input bit jmp = 1'b0, input logic [31:0] jpc = 32'h0,
                        input bit err_in = 1'b0);
        int   cnt;
        int   n;
        bit   mreq;
        req_t r;
        ent_t e;
        @(negedge clk);
        check_window();
        cnt  = exp_q.size();
        n    = jmp ? 0 : ((want < cnt) ? want : cnt);
        mreq = !halted && !jmp && (pend.size() < 2)
             && (cnt + FL * (pend.size() + 1) <= QL);
        bus.fetch_offset = 2'(n);
        bus.jump_vld     = jmp;
        bus.jump_pc      = jpc;
        bus.imem_gnt     = gnt_en;
        bus.imem_ack     = 1'b0;
        bus.imem_rdata   = '0;
        bus.imem_err     = 1'b0;
        #1;
        chk("imem_req", 32'(bus.imem_req), 32'(mreq));
        if (mreq && gnt_en) chk("imem_addr", bus.imem_addr, exp_req_pc);
        for (int i = 0; i < n; i++) void'(exp_q.pop_front());
        if (ack_en && pend.size() > 0) begin
            r = pend.pop_front();
            bus.imem_ack = 1'b1;
            bus.imem_err = err_in;
            for (int k = 0; k < FL; k++) bus.imem_rdata[k*32 +: 32] = mem_word(r.addr + 4 * k);
            if (!r.drop && !jmp) begin
                for (int k = 0; k < FL; k++) begin
                    e.pc    = r.addr + 4 * k;
                    e.instr = mem_word(e.pc);
                    e.err   = err_in;
                    exp_q.push_back(e);
                end
                if (err_in) halted = 1'b1;
            end
        end
        if (jmp) begin
            exp_q.delete();
            foreach (pend[i]) pend[i].drop = 1'b1;
            halted     = 1'b0;
            exp_req_pc = {jpc[31:2], 2'b00};
        end
        if (mreq && gnt_en) begin
            r.addr = exp_req_pc;
            r.drop = 1'b0;
            pend.push_back(r);
            exp_req_pc += 32'(4 * FL);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"}, 32'(bus.imem_req), 32'h0);
        chk({tag, "_vld"}, 32'(bus.fetch_vld), 32'h0);
        chk({tag, "_err"}, 32'(bus.fetch_err), 32'h0);
        chk({tag, "_pc0"}, bus.fetch_pc[31:0], 32'h0);
        chk({tag, "_pc1"}, bus.fetch_pc[63:32], 32'h0);
        chk({tag, "_instr0"}, bus.fetch_instr[31:0], 32'h0);
        chk({tag, "_instr1"}, bus.fetch_instr[63:32], 32'h0);
    endtask

    task automatic idle_inputs();
        bus.imem_gnt     = 1'b0;
        bus.imem_ack     = 1'b0;
        bus.imem_rdata   = '0;
        bus.imem_err     = 1'b0;
        bus.fetch_offset = '0;
        bus.jump_vld     = 1'b0;
        bus.jump_pc      = '0;
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        halted     = 1'b0;
        exp_req_pc = 32'h0;
        idle_inputs();
        #2;
        check_all_zero("reset");
        chk("reset_addr", bus.imem_addr, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Streaming: grant always, ack one cycle later, consume two per cycle.
        repeat (12) step(2, 1'b1, 1'b1);

        // Fill without consuming until credit stops requests, then free two slots.
        repeat (8) step(0, 1'b1, 1'b1);
        repeat (2) step(1, 1'b1, 1'b1);
        repeat (4) step(2, 1'b1, 1'b1);

        // Two outstanding at 0x20/0x28, then redirect: both responses must vanish.
        repeat (6) step(2, 1'b0, 1'b1);
        step(0, 1'b0, 1'b0, 1'b1, 32'h20);
        repeat (3) step(0, 1'b1, 1'b0);
        step(0, 1'b1, 1'b0, 1'b1, 32'h103);
        repeat (8) step(2, 1'b1, 1'b1);

        // Bus error at 0x40 halts fetching until a redirect to 0x80.
        repeat (6) step(2, 1'b0, 1'b1);
        step(0, 1'b0, 1'b0, 1'b1, 32'h40);
        step(0, 1'b1, 1'b0);
        step(0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (3) step(0, 1'b1, 1'b0);
        step(2, 1'b1, 1'b0);
        step(0, 1'b0, 1'b0, 1'b1, 32'h80);
        repeat (6) step(2, 1'b1, 1'b1);

        // Same-cycle ack and consume, odd consumes so the head crosses the wrap.
        for (int i = 0; i < 16; i++) step((i % 2 == 0) ? 1 : 2, 1'b1, 1'b1);
        repeat (6) step(2, 1'b1, 1'b1);

        // Asynchronous reset with a request outstanding.
        step(0, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        pend.delete();
        halted     = 1'b0;
        exp_req_pc = 32'h0;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        repeat (8) step(2, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
